// File: rtl/switch_debouncer.sv
// Two-flop synchronizer followed by an independent stability counter per switch bit.
// A bit's debounced level changes only after the new level has been seen for DEBOUNCE_CYCLES clocks in a row.
module switch_debouncer #(
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw_debounced,
   output logic [WIDTH-1:0] changed_mask,
   output logic             change_pulse
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [WIDTH-1:0] sync1_q;
   logic [WIDTH-1:0] sync2_q;
   logic [WIDTH-1:0] deb_q;
   logic [WIDTH-1:0] deb_d;
   logic [WIDTH-1:0] mask_q;
   logic [WIDTH-1:0] mask_d;
   logic             pulse_q;
   logic [CNT_W-1:0] cnt_q [WIDTH];
   logic [CNT_W-1:0] cnt_d [WIDTH];

   // Any return to the stable level clears the count, so counts never accumulate across glitches.
   always_comb begin
      deb_d  = deb_q;
      mask_d = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != deb_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               deb_d[i]  = sync2_q[i];
               mask_d[i] = 1'b1;
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         deb_q   <= '0;
         mask_q  <= '0;
         pulse_q <= 1'b0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sync1_q <= sw_raw;
         sync2_q <= sync1_q;
         deb_q   <= deb_d;
         mask_q  <= mask_d;
         pulse_q <= |mask_d;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign sw_debounced = deb_q;
   assign changed_mask = mask_q;
   assign change_pulse = pulse_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: a sample-window reference model checked every clock, plus
// directed scenarios with hand-computed literal expectations and a randomized bounce phase.
module tb_switch_debouncer;

   localparam int WIDTH = 8;
   localparam int DEB   = 4;

   logic             clk;
   logic             reset_n;
   logic [WIDTH-1:0] sw_raw;
   logic [WIDTH-1:0] sw_debounced;
   logic [WIDTH-1:0] changed_mask;
   logic             change_pulse;

   int vectors;
   int miscompares;

   switch_debouncer #(
      .WIDTH(WIDTH),
      .DEBOUNCE_CYCLES(DEB),
      .CNT_W(3)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .sw_raw(sw_raw),
      .sw_debounced(sw_debounced),
      .changed_mask(changed_mask),
      .change_pulse(change_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: a bit flips at an edge when the raw samples taken DEB+1 .. 2 edges earlier all
   // differ from its current debounced level. Samples from before reset count as 0.
   logic [WIDTH-1:0] hist[$];
   logic [WIDTH-1:0] expDeb;
   logic [WIDTH-1:0] expMask;
   logic             expPulse;

   always @(posedge clk) begin
      logic [WIDTH-1:0] nextMask;
      logic [WIDTH-1:0] sample;
      logic             allDiff;
      int               n;
      if (!reset_n) begin
         hist.delete();
         expDeb   = '0;
         expMask  = '0;
         expPulse = 1'b0;
      end else begin
         hist.push_back(sw_raw);
         n = hist.size() - 1;
         nextMask = '0;
         for (int i = 0; i < WIDTH; i++) begin
            allDiff = 1'b1;
            for (int j = n - 1 - DEB; j <= n - 2; j++) begin
               sample = (j >= 0) ? hist[j] : '0;
               if (sample[i] == expDeb[i]) allDiff = 1'b0;
            end
            if (allDiff) nextMask[i] = 1'b1;
         end
         expDeb   = expDeb ^ nextMask;
         expMask  = nextMask;
         expPulse = |nextMask;
      end
      #1;
      vectors++;
      if (sw_debounced !== expDeb || changed_mask !== expMask || change_pulse !== expPulse) begin
         miscompares++;
         $display("[TB] FAIL model t=%0t got deb=%h mask=%h pulse=%b expected deb=%h mask=%h pulse=%b",
                  $time, sw_debounced, changed_mask, change_pulse, expDeb, expMask, expPulse);
      end
   end

   // Inputs and literal checks happen on the falling edge, away from the sampling edge.
   task automatic applyStimulus(input logic [WIDTH-1:0] raw, input int waitClocks);
      sw_raw = raw;
      repeat (waitClocks) @(negedge clk);
   endtask

   task automatic checkOutput(input string name, input logic [WIDTH-1:0] deb,
                              input logic [WIDTH-1:0] mask, input logic pulse);
      vectors++;
      if (sw_debounced !== deb || changed_mask !== mask || change_pulse !== pulse) begin
         miscompares++;
         $display("[TB] FAIL %s got deb=%h mask=%h pulse=%b expected deb=%h mask=%h pulse=%b",
                  name, sw_debounced, changed_mask, change_pulse, deb, mask, pulse);
      end
   endtask

   task automatic resetAndSettle(input logic [WIDTH-1:0] raw);
      sw_raw  = raw;
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   initial begin
      int pulses;
      logic [WIDTH-1:0] r;
      vectors     = 0;
      miscompares = 0;
      reset_n     = 1'b0;
      sw_raw      = 8'hFF;

      // Reset with all switches high: reported as a normal change after the full latency.
      repeat (3) @(negedge clk);
      checkOutput("in_reset", 8'h00, 8'h00, 1'b0);
      reset_n = 1'b1;
      applyStimulus(8'hFF, 5);
      checkOutput("reset_before", 8'h00, 8'h00, 1'b0);
      applyStimulus(8'hFF, 1);
      checkOutput("reset_update", 8'hFF, 8'hFF, 1'b1);
      applyStimulus(8'hFF, 1);
      checkOutput("reset_mask_clear", 8'hFF, 8'h00, 1'b0);

      // Clean single-bit transition.
      resetAndSettle(8'h00);
      applyStimulus(8'h01, 5);
      checkOutput("clean_before", 8'h00, 8'h00, 1'b0);
      applyStimulus(8'h01, 1);
      checkOutput("clean_update", 8'h01, 8'h01, 1'b1);
      applyStimulus(8'h01, 1);
      checkOutput("clean_after", 8'h01, 8'h00, 1'b0);

      // Bounce on bit 3, then hold high.
      applyStimulus(8'h09, 1);
      applyStimulus(8'h01, 1);
      applyStimulus(8'h09, 1);
      applyStimulus(8'h09, 1);
      applyStimulus(8'h01, 1);
      checkOutput("bounce_during", 8'h01, 8'h00, 1'b0);
      applyStimulus(8'h09, 5);
      checkOutput("bounce_before", 8'h01, 8'h00, 1'b0);
      applyStimulus(8'h09, 1);
      checkOutput("bounce_update", 8'h09, 8'h08, 1'b1);

      // Three-clock pulse on bit 7 never propagates.
      applyStimulus(8'h89, 3);
      sw_raw = 8'h09;
      pulses = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (change_pulse) pulses++;
      end
      vectors++;
      if (pulses != 0) begin
         miscompares++;
         $display("[TB] FAIL short_pulse got %0d pulses expected 0", pulses);
      end
      checkOutput("short_pulse_level", 8'h09, 8'h00, 1'b0);

      // Simultaneous bits 0 and 5 (bit 0 already high, so add bit 5 with it), then staggered.
      applyStimulus(8'h29, 5);
      checkOutput("simul_before", 8'h09, 8'h00, 1'b0);
      applyStimulus(8'h29, 1);
      checkOutput("simul_update", 8'h29, 8'h20, 1'b1);
      resetAndSettle(8'h00);
      applyStimulus(8'h21, 6);
      checkOutput("simul_pair", 8'h21, 8'h21, 1'b1);
      applyStimulus(8'h21, 1);
      checkOutput("simul_pair_clear", 8'h21, 8'h00, 1'b0);
      applyStimulus(8'h23, 2);
      applyStimulus(8'h27, 3);
      checkOutput("stagger_before", 8'h21, 8'h00, 1'b0);
      applyStimulus(8'h27, 1);
      checkOutput("stagger_bit1", 8'h23, 8'h02, 1'b1);
      applyStimulus(8'h27, 1);
      checkOutput("stagger_gap", 8'h23, 8'h00, 1'b0);
      applyStimulus(8'h27, 1);
      checkOutput("stagger_bit2", 8'h27, 8'h04, 1'b1);

      // Reset mid-count on bit 4 discards the partial count.
      resetAndSettle(8'h00);
      applyStimulus(8'h10, 3);
      reset_n = 1'b0;
      @(negedge clk);
      checkOutput("midreset_during", 8'h00, 8'h00, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      applyStimulus(8'h10, 5);
      checkOutput("midreset_before", 8'h00, 8'h00, 1'b0);
      applyStimulus(8'h10, 1);
      checkOutput("midreset_update", 8'h10, 8'h10, 1'b1);

      // Randomized bouncing with occasional resets, checked by the model every clock.
      r = 8'h10;
      for (int k = 0; k < 3000; k++) begin
         for (int b = 0; b < WIDTH; b++) begin
            if ($urandom_range(5) == 0) r[b] = ~r[b];
         end
         sw_raw = r;
         if ($urandom_range(399) == 0) reset_n = 1'b0;
         else reset_n = 1'b1;
         @(negedge clk);
      end
      reset_n = 1'b1;
      repeat (10) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/switch_debouncer.md
# switch_debouncer

Synchronizes and debounces the raw slide-switch inputs from the board pins. Produces clean, stable levels that drive the `in_port` of the switch PIO slave, which the Nios II reads over Avalon. Each bit is debounced independently with a per-bit stability counter. A one-cycle change pulse and per-bit change mask are provided for optional edge-capture or interrupt logic.

## Interface

**Parameters**

- `WIDTH`, default 8: number of switch bits.
- `DEBOUNCE_CYCLES`, default 500000: consecutive clocks a new level must hold before it is accepted (10 ms at 50 MHz). Legal range is ≥ 2.
- `CNT_W`, default 20: counter width. Must satisfy 2^CNT_W > `DEBOUNCE_CYCLES` − 1.

**Ports**

- `clk`, input, 1: system clock. All logic is on the rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `sw_raw`, input, `WIDTH`: asynchronous switch pins.
- `sw_debounced`, output, `WIDTH`: registered stable levels, wired to the PIO `in_port`.
- `changed_mask`, output, `WIDTH`: registered; bit i is high for one cycle when `sw_debounced[i]` updates.
- `change_pulse`, output, 1: registered OR of `changed_mask`.

## Operation

**Synchronizer**
- Two flops per bit: `sync1 <= sw_raw`, `sync2 <= sync1`.
- Both reset to 0.

**Per-bit debounce (bit i), evaluated every edge**
- If `sync2[i] == sw_debounced[i]`: `cnt[i] <= 0` and `changed_mask[i] <= 0`.
- Else, if `cnt[i] == DEBOUNCE_CYCLES-1`: `sw_debounced[i] <= sync2[i]`, `cnt[i] <= 0`, `changed_mask[i] <= 1`.
- Else: `cnt[i] <= cnt[i]+1` and `changed_mask[i] <= 0`.

**Behaviour rules**
- **Glitch:** any return of `sync2[i]` to the stable level before the count completes clears `cnt[i]`. The counter never accumulates across glitches.
- **Counter bounds:** the counter never exceeds `DEBOUNCE_CYCLES-1`, so there is no wrap.
- **Bit independence:** bits are fully independent. Simultaneous updates on several bits set several mask bits in the same cycle, with a single `change_pulse` cycle.
- **Change pulse:** `change_pulse <= |next_changed_mask` is registered in the same cycle as the mask, so it is coincident with `changed_mask`.

**Reset**
- On reset, all outputs, counters and sync flops are 0.
- Reset asserted mid-count discards the partial count.
- Switches that are high out of reset are reported as a normal 0→1 change, including the mask and pulse, after the full latency.

## Timing

- **Latency:** a raw level change first sampled at edge k appears on `sw_debounced` after edge k+1+`DEBOUNCE_CYCLES`. That is `DEBOUNCE_CYCLES`+2 clocks, provided the level holds throughout.
- **Mask/pulse timing:** `changed_mask` and `change_pulse` are high for exactly the one cycle in which `sw_debounced` takes its new value.
- **Minimum pulse:** a raw pulse shorter than `DEBOUNCE_CYCLES` clocks, measured at `sync2`, never reaches the output.
- **No combinational paths:** there is no combinational path from `sw_raw` to any output. All outputs come directly from flops.
- **Throughput:** a bit can toggle at most once every `DEBOUNCE_CYCLES` clocks. After one update, the opposite level must again hold for a full `DEBOUNCE_CYCLES`.

## Test plan

All scenarios use `DEBOUNCE_CYCLES`=4 and `WIDTH`=8.

1. **Reset:** hold `reset_n`=0 with `sw_raw`=0xFF, then release at edge 0.
   - Expect all outputs 0 during reset.
   - Expect `sw_debounced`=0xFF, `changed_mask`=0xFF and `change_pulse`=1 for one cycle, 6 clocks after release.
   - Expect the mask to return to 0x00 on the next cycle.
2. **Clean transition:** from a stable 0x00, set `sw_raw`=0x01 and hold.
   - Expect `sw_debounced`=0x01 exactly 6 clocks later.
   - Expect `changed_mask`=0x01 for one cycle.
   - Expect no change earlier.
3. **Bounce:** toggle bit 3 as 1,0,1,1,0, one clock each, then hold at 1.
   - Expect no output change during the bouncing.
   - Expect `sw_debounced[3]`=1 exactly 6 clocks after the final rising edge of the input.
4. **Short pulse:** drive a 3-clock high pulse on bit 7.
   - Expect `sw_debounced` to stay 0x00.
   - Expect `change_pulse` never to assert.
5. **Simultaneous and staggered bits:**
   - Set bits 0 and 5 on the same edge: expect one pulse cycle with `changed_mask`=0x21.
   - Then set bit 2 two clocks after bit 1: expect separate mask cycles 0x02 and 0x04, two clocks apart.
6. **Mid-count reset:** start a 0→1 change on bit 4, assert `reset_n` after 3 clocks, release while holding the raw input high.
   - Expect the output to stay 0 during and after reset.
   - Expect the update to occur a full 6 clocks after release, not sooner.
